register_file: RTL and testbench

Two-read/one-write register file that sits directly upstream of the ALU and drives its `A` and `B` operand buses. It captures operands on the clock edge, forwards same-cycle write-back data, and keeps a per-register pending-write scoreboard. When a requested source has an outstanding write, it raises `stall` so the issue logic holds the instruction.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/register_scoreboard.sv | 55 +++++
 rtl/register_file.sv | 97 +++++++++
 tb/tb_register_file.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file, ALU operand path and issue logic.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/register_scoreboard.sv
// Per-register pending-write tracking: reserve on issue, clear on write-back,
// and hazard flags for the two read ports.
module register_scoreboard #(
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reserve_en,
  input  logic [ADDR_WIDTH-1:0] reserve_addr,
  input  logic                  clear_en,
  input  logic [ADDR_WIDTH-1:0] clear_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic                  hazA,
  output logic                  hazB
);
  import regfile_pkg::*;

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic             clear_a;
  logic             clear_b;

  // Reserve is applied after clear so a same-edge re-reservation keeps the bit set.
  always_comb begin
    busy_next = busy;
    if (clear_en && (clear_addr != ZERO_ADDR)) begin
      busy_next[clear_addr] = 1'b0;
    end
    if (reserve_en && (reserve_addr != ZERO_ADDR)) begin
      busy_next[reserve_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // A write-back landing this cycle resolves the hazard through forwarding.
  always_comb begin
    clear_a = clear_en && (clear_addr == rd_addr_a);
    clear_b = clear_en && (clear_addr == rd_addr_b);
    hazA    = busy[rd_addr_a] && !clear_a;
    hazB    = busy[rd_addr_b] && !clear_b;
  end

endmodule

// File: rtl/register_file.sv
// Two-read/one-write register file feeding the ALU operand buses, with
// write-back forwarding and a pending-write scoreboard that raises stall.
module register_file #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic                  dst_en,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic                  op_valid,
  output logic                  stall
);
  import regfile_pkg::*;

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic                  hazA;
  logic                  hazB;
  logic                  accept;
  logic                  reserve_en;
  logic [DATA_WIDTH-1:0] opnd_a;
  logic [DATA_WIDTH-1:0] opnd_b;

  // Issue handshake: rd_en is the request, stall is the combinational refusal,
  // and an accept (rd_en & !stall) yields op_valid with A/B on the next cycle.
  assign stall      = rd_en && (hazA || hazB);
  assign accept     = rd_en && !stall;
  assign reserve_en = accept && dst_en;

  register_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .reserve_en   (reserve_en),
    .reserve_addr (dst_addr),
    .clear_en     (wr_en),
    .clear_addr   (wr_addr),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .hazA         (hazA),
    .hazB         (hazB)
  );

  always_comb begin
    if (rd_addr_a == ZERO_ADDR) begin
      opnd_a = '0;
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      opnd_a = wr_data;
    end else begin
      opnd_a = regs[rd_addr_a];
    end
    if (rd_addr_b == ZERO_ADDR) begin
      opnd_b = '0;
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      opnd_b = wr_data;
    end else begin
      opnd_b = regs[rd_addr_b];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != ZERO_ADDR)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A        <= '0;
      B        <= '0;
      op_valid <= 1'b0;
    end else begin
      op_valid <= accept;
      if (accept) begin
        A <= opnd_a;
        B <= opnd_b;
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, async reset
// and throughput sequences, then randomized traffic against a reference model.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic        dst_en;
  logic [4:0]  dst_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] A;
  logic [31:0] B;
  logic        op_valid;
  logic        stall;

  register_file #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .dst_en    (dst_en),
    .dst_addr  (dst_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .A         (A),
    .B         (B),
    .op_valid  (op_valid),
    .stall     (stall)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model state
  logic [31:0] mem [32];
  bit          pend [32];
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_valid;
  logic [63:0] exp_q[$];
  logic        last_stall;

  typedef struct {
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        de;
    logic [4:0]  da;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_a;
    logic [31:0] e_b;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem[i]  = '0;
      pend[i] = 1'b0;
    end
    m_a     = '0;
    m_b     = '0;
    m_valid = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] m_val(input logic [4:0] addr, input logic we,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (addr == 5'd0) return 32'd0;
    if (we && wa == addr) return wd;
    return mem[addr];
  endfunction

  function automatic bit m_hazard(input logic [4:0] addr, input logic we, input logic [4:0] wa);
    return pend[addr] && !(we && wa == addr);
  endfunction

  // Driver: one issue cycle, checked against the model on both halves.
  task automatic step(input logic re, input logic [4:0] ra, input logic [4:0] rb,
                      input logic de, input logic [4:0] da,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    bit          exp_stall;
    bit          acc;
    logic [63:0] head;
    rd_en = re; rd_addr_a = ra; rd_addr_b = rb;
    dst_en = de; dst_addr = da;
    wr_en = we; wr_addr = wa; wr_data = wd;
    @(negedge clk);
    exp_stall = re && (m_hazard(ra, we, wa) || m_hazard(rb, we, wa));
    last_stall = stall;
    check("stall", {31'd0, stall}, {31'd0, exp_stall});
    acc = re && !exp_stall;
    if (acc) begin
      m_a = m_val(ra, we, wa, wd);
      m_b = m_val(rb, we, wa, wd);
      exp_q.push_back({m_a, m_b});
    end
    m_valid = acc;
    if (we && wa != 5'd0) begin
      mem[wa]  = wd;
      pend[wa] = 1'b0;
    end
    if (acc && de && da != 5'd0) pend[da] = 1'b1;
    @(posedge clk);
    #1;
    check("op_valid", {31'd0, op_valid}, {31'd0, m_valid});
    check("A_hold", A, m_a);
    check("B_hold", B, m_b);
    if (op_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_op_valid", 32'd1, 32'd0);
      end else begin
        head = exp_q.pop_front();
        check("sb_A", A, head[63:32]);
        check("sb_B", B, head[31:0]);
      end
    end
  endtask

  initial begin
    int run;
    checks   = 0;
    failures = 0;
    model_reset();

    // Directed table: reset/zero reg, forwarding, hazard stall, reserve-wins.
    vecs[0]  = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[1]  = '{1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 32'h12345678};
    vecs[2]  = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[3]  = '{1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[4]  = '{1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h55, 1'b0, 1'b1, 32'h55, 32'h0};
    vecs[5]  = '{1'b1, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h12345678, 32'h55};
    vecs[6]  = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[7]  = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h1, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[8]  = '{1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 5'd0, 5'd9, 1'b0, 5'd0, 1'b1, 5'd9, 32'h2, 1'b0, 1'b1, 32'h0, 32'h2};
    vecs[10] = '{1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h2, 32'h2};
    vecs[11] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h2, 32'h2};
    vecs[12] = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd11, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[13] = '{1'b0, 5'd11, 5'd11, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0};

    rst = 1'b1;
    rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    dst_en = 1'b0; dst_addr = '0;
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_A", A, 32'h0);
    check("reset_B", B, 32'h0);
    check("reset_op_valid", {31'd0, op_valid}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].re, vecs[i].ra, vecs[i].rb, vecs[i].de, vecs[i].da,
           vecs[i].we, vecs[i].wa, vecs[i].wd);
      check($sformatf("vec%0d_stall", i), {31'd0, last_stall}, {31'd0, vecs[i].e_stall});
      check($sformatf("vec%0d_valid", i), {31'd0, op_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("vec%0d_A", i), A, vecs[i].e_a);
      check($sformatf("vec%0d_B", i), B, vecs[i].e_b);
    end

    // Async reset between edges with r3 written and r4 pending.
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hFF);
    step(1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0);
    check("pre_rst_A", A, 32'hFF);
    #1 rst = 1'b1;
    #1;
    check("async_rst_A", A, 32'h0);
    check("async_rst_B", B, 32'h0);
    check("async_rst_valid", {31'd0, op_valid}, 32'd0);
    check("async_rst_stall", {31'd0, stall}, 32'd0);
    #1 rst = 1'b0;
    model_reset();
    step(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
    check("post_rst_r3", A, 32'h0);
    check("post_rst_r4_nostall", {31'd0, last_stall}, 32'd0);

    // Back-to-back accepts with no reservations.
    run = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0, 5'd0,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      if (op_valid) run++;
    end
    check("b2b_run", run, 32'd8);

    // Randomized traffic concentrated on a few registers to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
